// File: rtl/signal_query_arbiter_if.sv
// signal_query_arbiter_if: requester, result and engine signals of the query arbiter.
// Stats ports exist only when SIGNAL_QUERY_ARBITER_STATS_EN is defined.
interface signal_query_arbiter_if #(
    parameter int NUM_REQ     = 3,
    parameter int QUERY_WIDTH = 32,
    parameter int TIME_WIDTH  = 32
);
    logic [NUM_REQ-1:0]             req_i;
    logic [NUM_REQ*QUERY_WIDTH-1:0] query_i;
    logic [NUM_REQ-1:0]             grant_o;
    logic [NUM_REQ-1:0]             result_valid_o;
    logic [2*TIME_WIDTH-1:0]        result_o;
    logic                           timeout_o;
    logic [QUERY_WIDTH-1:0]         eng_value_o;
    logic                           eng_recalculate_o;
    logic                           eng_data_valid_i;
    logic [2*TIME_WIDTH-1:0]        eng_time_out_i;
`ifdef SIGNAL_QUERY_ARBITER_STATS_EN
    logic [NUM_REQ*16-1:0]          grant_count_o;
    logic [15:0]                    max_wait_o;
`endif

    modport master (
        output req_i, query_i, eng_data_valid_i, eng_time_out_i,
`ifdef SIGNAL_QUERY_ARBITER_STATS_EN
        input  grant_count_o, max_wait_o,
`endif
        input  grant_o, result_valid_o, result_o, timeout_o, eng_value_o, eng_recalculate_o
    );

    modport slave (
        input  req_i, query_i, eng_data_valid_i, eng_time_out_i,
`ifdef SIGNAL_QUERY_ARBITER_STATS_EN
        output grant_count_o, max_wait_o,
`endif
        output grant_o, result_valid_o, result_o, timeout_o, eng_value_o, eng_recalculate_o
    );
endinterface

// File: rtl/signal_query_arbiter.sv
// signal_query_arbiter: round-robin sharing of one signal-history query engine with a timeout guard.
// Define SIGNAL_QUERY_ARBITER_STATS_EN to add per-requester grant counters and max-wait tracking.
module signal_query_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int QUERY_WIDTH    = 32,
    parameter int TIME_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic                   clk,
    input logic                   rst_n,
    signal_query_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PW    = IDX_W + 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [IDX_W-1:0]        r_rr_ptr;
    logic [IDX_W-1:0]        r_idx;
    logic [IDX_W-1:0]        w_sel;
    logic [PW-1:0]           w_pos;
    logic                    w_any;
    logic [QUERY_WIDTH-1:0]  r_query;
    logic [2*TIME_WIDTH-1:0] r_result;
    logic                    r_timeout;
    logic [CNT_W-1:0]        r_wait_cnt;
    logic                    w_expire;
    logic                    w_done;
    logic [NUM_REQ-1:0]      w_onehot;

    assign w_any    = |bus.req_i;
    assign w_expire = r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    assign w_done   = r_state == WAIT && (bus.eng_data_valid_i || w_expire);
    assign w_onehot = NUM_REQ'(1) << r_idx;

    // Scan downward so the requester closest above rr_ptr is the one left selected
    always_comb begin
        w_sel = r_rr_ptr;
        w_pos = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_pos = {1'b0, r_rr_ptr} + PW'(i);
            w_pos = (w_pos >= PW'(NUM_REQ)) ? w_pos - PW'(NUM_REQ) : w_pos;
            if (bus.req_i[w_pos[IDX_W-1:0]]) w_sel = w_pos[IDX_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_any ? ISSUE : IDLE;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = w_done ? RESPOND : WAIT;
            RESPOND: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr   <= '0;
            r_idx      <= '0;
            r_query    <= '0;
            r_result   <= '0;
            r_timeout  <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            if (r_state == IDLE && w_any) begin
                r_idx   <= w_sel;
                r_query <= bus.query_i[w_sel*QUERY_WIDTH +: QUERY_WIDTH];
            end
            if (r_state == ISSUE) r_wait_cnt <= '0;
            if (r_state == WAIT) r_wait_cnt <= r_wait_cnt + 1'b1;
            // A valid arriving on the expiry cycle still wins
            if (w_done) begin
                r_result  <= bus.eng_data_valid_i ? bus.eng_time_out_i : '1;
                r_timeout <= !bus.eng_data_valid_i;
            end
            if (r_state == RESPOND) r_rr_ptr <= (r_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_idx + 1'b1;
        end
    end

    assign bus.grant_o           = (r_state != IDLE) ? w_onehot : '0;
    assign bus.result_valid_o    = (r_state == RESPOND) ? w_onehot : '0;
    assign bus.result_o          = r_result;
    assign bus.timeout_o         = r_state == RESPOND && r_timeout;
    assign bus.eng_value_o       = r_query;
    assign bus.eng_recalculate_o = r_state == ISSUE || r_state == WAIT;

`ifdef SIGNAL_QUERY_ARBITER_STATS_EN
    logic [NUM_REQ*16-1:0] r_grant_count;
    logic [15:0]           r_max_wait;
    logic [31:0]           w_wait_len;
    logic [15:0]           w_wait_sat;

    assign w_wait_len = 32'(r_wait_cnt) + 32'd1;
    assign w_wait_sat = (w_wait_len > 32'hFFFF) ? 16'hFFFF : w_wait_len[15:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_count <= '0;
            r_max_wait    <= '0;
        end else begin
            if (w_done && w_wait_sat > r_max_wait) r_max_wait <= w_wait_sat;
            for (int k = 0; k < NUM_REQ; k++)
                if (r_state == RESPOND && r_idx == IDX_W'(k) && r_grant_count[k*16 +: 16] != 16'hFFFF)
                    r_grant_count[k*16 +: 16] <= r_grant_count[k*16 +: 16] + 16'd1;
        end
    end

    assign bus.grant_count_o = r_grant_count;
    assign bus.max_wait_o    = r_max_wait;
`endif
endmodule

// File: tb/tb_signal_query_arbiter.sv
// tb_signal_query_arbiter: directed stimulus with a scoreboard queue checked by an independent result monitor.
module tb_signal_query_arbiter;
    localparam int NR = 3;
    localparam int QW = 32;
    localparam int TW = 32;
    localparam int TO = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    signal_query_arbiter_if #(.NUM_REQ(NR), .QUERY_WIDTH(QW), .TIME_WIDTH(TW)) bus ();

    signal_query_arbiter #(
        .NUM_REQ(NR), .QUERY_WIDTH(QW), .TIME_WIDTH(TW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    typedef struct {
        int          idx;
        logic [63:0] res;
        logic        to;
    } exp_t;

    exp_t sb[$];
    int   n_tests   = 0;
    int   n_fail    = 0;
    int   eng_delay = 0;
    int   eng_c     = 0;
    logic eng_auto  = 1'b0;
    logic eng_force = 1'b0;

    // Engine model: answers {value+4, value+2} on the eng_delay-th WAIT cycle (0 = never)
    assign bus.eng_data_valid_i = eng_auto | eng_force;
    assign bus.eng_time_out_i   = {bus.eng_value_o + 32'd4, bus.eng_value_o + 32'd2};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] eres(input int q);
        return {32'(q + 4), 32'(q + 2)};
    endfunction

    task automatic push(input int idx, input logic [63:0] r, input logic to);
        exp_t e;
        e.idx = idx;
        e.res = r;
        e.to  = to;
        sb.push_back(e);
    endtask

    task automatic set_query(input int k, input int q);
        bus.query_i[k*QW +: QW] = 32'(q);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            eng_c    = bus.eng_recalculate_o ? eng_c + 1 : 0;
            eng_auto = eng_delay != 0 && eng_c == eng_delay + 1;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (|bus.result_valid_o) begin
                if (sb.size() == 0) chk("unexpected_result", 64'(bus.result_valid_o), 64'd0);
                else begin
                    e = sb.pop_front();
                    chk("result_valid", 64'(bus.result_valid_o), 64'(3'b001 << e.idx));
                    chk("result_data", bus.result_o, e.res);
                    chk("result_timeout", 64'(bus.timeout_o), 64'(e.to));
                    chk("respond_recalc_low", 64'(bus.eng_recalculate_o), 64'd0);
                    chk("respond_grant", 64'(bus.grant_o), 64'(bus.result_valid_o));
                end
            end
        end
    end

    task automatic wait_grant(output int ok);
        ok = 0;
        for (int i = 0; i < 50 && ok == 0; i++) begin
            @(negedge clk);
            if (|bus.grant_o) ok = 1;
        end
        if (ok == 0) chk("grant_wait_expired", 64'd0, 64'd1);
    endtask

    task automatic serve(input int n, input bit drop);
        int got;
        got = 0;
        for (int i = 0; i < 500 && got < n; i++) begin
            @(negedge clk);
            if (|bus.result_valid_o) begin
                got++;
                if (drop) bus.req_i = bus.req_i & ~bus.result_valid_o;
            end
        end
        chk("results_seen", 64'(got), 64'(n));
    endtask

    task automatic do_single(input int idx, input int q, input int d, input bit stale);
        int ok;
        int lat;
        eng_delay = d;
        if (stale) begin
            @(negedge clk);
            eng_force = 1'b1;
            @(negedge clk);
            eng_force = 1'b0;
        end
        set_query(idx, q);
        bus.req_i[idx] = 1'b1;
        push(idx, (d == 0) ? '1 : eres(q), d == 0);
        wait_grant(ok);
        if (ok != 0) begin
            if (stale) eng_force = 1'b1;
            chk("issue_value", 64'(bus.eng_value_o), 64'(q));
            chk("issue_recalc", 64'(bus.eng_recalculate_o), 64'd1);
            chk("issue_grant", 64'(bus.grant_o), 64'(3'b001 << idx));
            lat = 0;
            while (lat < 400 && !bus.result_valid_o[idx]) begin
                @(negedge clk);
                eng_force = 1'b0;
                lat++;
            end
            chk("latency", 64'(lat), 64'((d == 0) ? TO + 1 : d + 1));
        end
        bus.req_i[idx] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int ok;
        bus.req_i   = '0;
        bus.query_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant", 64'(bus.grant_o), 64'd0);
        chk("rst_result_valid", 64'(bus.result_valid_o), 64'd0);
        chk("rst_result", bus.result_o, 64'd0);
        chk("rst_timeout", 64'(bus.timeout_o), 64'd0);
        chk("rst_eng_value", 64'(bus.eng_value_o), 64'd0);
        chk("rst_recalc", 64'(bus.eng_recalculate_o), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_single(1, 5, 3, 1'b0);
        do_single(0, 40, 2, 1'b1);
        do_single(0, 77, 0, 1'b0);

        eng_delay = 0;
        set_query(1, 55);
        bus.req_i[1] = 1'b1;
        wait_grant(ok);
        chk("midwait_grant", 64'(bus.grant_o), 64'b010);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_grant", 64'(bus.grant_o), 64'd0);
        chk("midrst_result", bus.result_o, 64'd0);
        chk("midrst_eng_value", 64'(bus.eng_value_o), 64'd0);
        chk("midrst_recalc", 64'(bus.eng_recalculate_o), 64'd0);
        bus.req_i = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        eng_delay = 2;
        set_query(0, 60);
        set_query(1, 55);
        push(0, eres(60), 1'b0);
        push(1, eres(55), 1'b0);
        bus.req_i = 3'b011;
        wait_grant(ok);
        chk("post_reset_grant", 64'(bus.grant_o), 64'b001);
        serve(2, 1'b1);

        eng_delay = 1;
        set_query(0, 10);
        set_query(1, 20);
        set_query(2, 30);
        push(2, eres(30), 1'b0);
        push(0, eres(10), 1'b0);
        push(1, eres(20), 1'b0);
        push(2, eres(30), 1'b0);
        push(0, eres(10), 1'b0);
        push(1, eres(20), 1'b0);
        bus.req_i = 3'b111;
        serve(6, 1'b0);
        bus.req_i = '0;

        eng_delay = 3;
        set_query(0, 90);
        push(0, eres(90), 1'b0);
        bus.req_i = 3'b001;
        wait_grant(ok);
        set_query(0, 91);
        bus.req_i = 3'b100;
        @(negedge clk);
        bus.req_i = '0;
        serve(1, 1'b0);
        repeat (4) @(negedge clk);
        chk("withdraw_idle_grant", 64'(bus.grant_o), 64'd0);

`ifdef SIGNAL_QUERY_ARBITER_STATS_EN
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_single(1, 5, 3, 1'b0);
        do_single(1, 6, 5, 1'b0);
        @(negedge clk);
        chk("stats_count1", 64'(bus.grant_count_o[16 +: 16]), 64'd2);
        chk("stats_count0", 64'(bus.grant_count_o[0 +: 16]), 64'd0);
        chk("stats_max_wait", 64'(bus.max_wait_o), 64'd5);
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
